// File: rtl/pc_control_alu_pkg.sv
// Shared constants for the WISC-25 PC/control/ALU slice: opcodes, ALU-class
// codes, ALU operation selects and the default reset PC.
package pc_control_alu_pkg;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ALUOP_MEM    = 3'b000,
        ALUOP_BRANCH = 3'b001,
        ALUOP_RTYPE  = 3'b010,
        ALUOP_IMM    = 3'b011,
        ALUOP_UPPER  = 3'b100,
        ALUOP_JUMP   = 3'b101
    } alu_op_e;

    localparam logic [3:0] OPSEL_ADD  = 4'b0000;
    localparam logic [3:0] OPSEL_SUB  = 4'b1000;
    localparam logic [3:0] OPSEL_SLL  = 4'b0001;
    localparam logic [3:0] OPSEL_SLT  = 4'b0010;
    localparam logic [3:0] OPSEL_SLTU = 4'b0011;
    localparam logic [3:0] OPSEL_XOR  = 4'b0100;
    localparam logic [3:0] OPSEL_SRL  = 4'b0101;
    localparam logic [3:0] OPSEL_SRA  = 4'b1101;
    localparam logic [3:0] OPSEL_OR   = 4'b0110;
    localparam logic [3:0] OPSEL_AND  = 4'b0111;

endpackage

// File: rtl/pc_control_alu_if.sv
// Decode bus: opcode toward the decoder, datapath/flow strobes back to the hart.
interface pc_control_alu_if;
    logic [6:0] i_opcode;
    logic       o_alu_src;
    logic       o_mem_to_reg;
    logic       o_reg_write;
    logic       o_mem_read;
    logic       o_mem_write;
    logic       o_branch;
    logic       o_jump;
    logic       o_jalr;
    logic       o_load_upper_imm;
    logic       o_upper_imm;
    logic [2:0] o_alu_op;

    modport master (
        output i_opcode,
        input  o_alu_src, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write,
        input  o_branch, o_jump, o_jalr, o_load_upper_imm, o_upper_imm, o_alu_op
    );

    modport slave (
        input  i_opcode,
        output o_alu_src, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write,
        output o_branch, o_jump, o_jalr, o_load_upper_imm, o_upper_imm, o_alu_op
    );
endinterface

// File: rtl/pc_control_alu_alu_core.sv
// Combinational 32-bit integer ALU; unknown opsel codes produce zero.
module alu_core
    import pc_control_alu_pkg::*;
(
    input  logic [3:0]  i_opsel,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic [31:0] o_result,
    output logic        o_alu_zero
);

    logic [4:0] shamt;
    assign shamt = i_op2[4:0];

    always_comb begin
        o_result = 32'd0;
        case (i_opsel)
            OPSEL_ADD:  o_result = i_op1 + i_op2;
            OPSEL_SUB:  o_result = i_op1 - i_op2;
            OPSEL_SLL:  o_result = i_op1 << shamt;
            OPSEL_SLT:  o_result = {31'd0, $signed(i_op1) < $signed(i_op2)};
            OPSEL_SLTU: o_result = {31'd0, i_op1 < i_op2};
            OPSEL_XOR:  o_result = i_op1 ^ i_op2;
            OPSEL_SRL:  o_result = i_op1 >> shamt;
            OPSEL_SRA:  o_result = $unsigned($signed(i_op1) >>> shamt);
            OPSEL_OR:   o_result = i_op1 | i_op2;
            OPSEL_AND:  o_result = i_op1 & i_op2;
            default:    o_result = 32'd0;
        endcase
    end

    assign o_alu_zero = (o_result == 32'd0);

endmodule

// File: rtl/pc_control_alu.sv
// PC register, opcode decoder and ALU for the single-cycle WISC-25 hart.
// Optional in-core branch evaluation is enabled by defining BRANCH_EVAL_EN.
module pc_control_alu
    import pc_control_alu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        i_next_pc,
    output logic [31:0]        o_current_pc,
    pc_control_alu_if.slave    ctrl,
    input  logic [3:0]         i_opsel,
    input  logic [31:0]        i_op1,
    input  logic [31:0]        i_op2,
    output logic [31:0]        o_result,
    output logic               o_alu_zero,
    input  logic [2:0]         i_funct3,
    output logic               o_branch_taken
);

    logic [31:0] pc_reg;

    // No enable: the hart holds the PC by feeding it back as next PC.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) pc_reg <= RESET_ADDR;
        else        pc_reg <= i_next_pc;
    end

    assign o_current_pc = pc_reg;

    always_comb begin
        ctrl.o_alu_src        = 1'b0;
        ctrl.o_mem_to_reg     = 1'b0;
        ctrl.o_reg_write      = 1'b0;
        ctrl.o_mem_read       = 1'b0;
        ctrl.o_mem_write      = 1'b0;
        ctrl.o_branch         = 1'b0;
        ctrl.o_jump           = 1'b0;
        ctrl.o_jalr           = 1'b0;
        ctrl.o_load_upper_imm = 1'b0;
        ctrl.o_upper_imm      = 1'b0;
        ctrl.o_alu_op         = ALUOP_MEM;
        case (ctrl.i_opcode)
            OP_RTYPE: begin
                ctrl.o_reg_write = 1'b1;
                ctrl.o_alu_op    = ALUOP_RTYPE;
            end
            OP_IMM: begin
                ctrl.o_alu_src   = 1'b1;
                ctrl.o_reg_write = 1'b1;
                ctrl.o_alu_op    = ALUOP_IMM;
            end
            OP_LOAD: begin
                ctrl.o_alu_src    = 1'b1;
                ctrl.o_mem_to_reg = 1'b1;
                ctrl.o_reg_write  = 1'b1;
                ctrl.o_mem_read   = 1'b1;
            end
            OP_STORE: begin
                ctrl.o_alu_src   = 1'b1;
                ctrl.o_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.o_branch = 1'b1;
                ctrl.o_alu_op = ALUOP_BRANCH;
            end
            OP_JAL: begin
                ctrl.o_jump      = 1'b1;
                ctrl.o_reg_write = 1'b1;
                ctrl.o_alu_op    = ALUOP_JUMP;
            end
            OP_JALR: begin
                ctrl.o_jalr      = 1'b1;
                ctrl.o_alu_src   = 1'b1;
                ctrl.o_reg_write = 1'b1;
                ctrl.o_alu_op    = ALUOP_JUMP;
            end
            OP_LUI: begin
                ctrl.o_load_upper_imm = 1'b1;
                ctrl.o_alu_src        = 1'b1;
                ctrl.o_reg_write      = 1'b1;
                ctrl.o_alu_op         = ALUOP_UPPER;
            end
            OP_AUIPC: begin
                ctrl.o_upper_imm = 1'b1;
                ctrl.o_alu_src   = 1'b1;
                ctrl.o_reg_write = 1'b1;
                ctrl.o_alu_op    = ALUOP_UPPER;
            end
            default: ;
        endcase
    end

    alu_core u_alu_core (
        .i_opsel    (i_opsel),
        .i_op1      (i_op1),
        .i_op2      (i_op2),
        .o_result   (o_result),
        .o_alu_zero (o_alu_zero)
    );

`ifdef BRANCH_EVAL_EN
    logic cond;

    // Compares raw operands so the decision is independent of the ALU opsel.
    always_comb begin
        cond = 1'b0;
        case (i_funct3)
            3'b000:  cond = (i_op1 == i_op2);
            3'b001:  cond = (i_op1 != i_op2);
            3'b100:  cond = ($signed(i_op1) <  $signed(i_op2));
            3'b101:  cond = ($signed(i_op1) >= $signed(i_op2));
            3'b110:  cond = (i_op1 <  i_op2);
            3'b111:  cond = (i_op1 >= i_op2);
            default: cond = 1'b0;
        endcase
    end

    assign o_branch_taken = ctrl.o_branch & cond;
`else
    logic unused_funct3;
    assign unused_funct3  = ^i_funct3;
    assign o_branch_taken = 1'b0;
`endif

endmodule

// File: tb/tb_pc_control_alu.sv
// Directed bench for pc_control_alu: reset, PC update/hold, decode, ALU, branch.
module tb_pc_control_alu;
    import pc_control_alu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_next_pc = 32'd0;
    logic [31:0] o_current_pc;
    logic [3:0]  i_opsel = 4'd0;
    logic [31:0] i_op1 = 32'd0;
    logic [31:0] i_op2 = 32'd0;
    logic [31:0] o_result;
    logic        o_alu_zero;
    logic [2:0]  i_funct3 = 3'd0;
    logic        o_branch_taken;

    int n_assert = 0;
    int n_fail   = 0;

    pc_control_alu_if ctrl_if ();

    pc_control_alu #(.RESET_ADDR(32'h0000_0100)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_next_pc      (i_next_pc),
        .o_current_pc   (o_current_pc),
        .ctrl           (ctrl_if.slave),
        .i_opsel        (i_opsel),
        .i_op1          (i_op1),
        .i_op2          (i_op2),
        .o_result       (o_result),
        .o_alu_zero     (o_alu_zero),
        .i_funct3       (i_funct3),
        .o_branch_taken (o_branch_taken)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) begin
            $display("ok   %s obs=%h", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe pack: alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump,jalr,lui,auipc,alu_op[2:0]
    task automatic chk_dec(input string tag, input logic [6:0] opc, input logic [12:0] exp);
        logic [12:0] obs;
        ctrl_if.i_opcode = opc;
        #1;
        obs = {ctrl_if.o_alu_src, ctrl_if.o_mem_to_reg, ctrl_if.o_reg_write,
               ctrl_if.o_mem_read, ctrl_if.o_mem_write, ctrl_if.o_branch,
               ctrl_if.o_jump, ctrl_if.o_jalr, ctrl_if.o_load_upper_imm,
               ctrl_if.o_upper_imm, ctrl_if.o_alu_op};
        chk32(tag, {19'd0, obs}, {19'd0, exp});
    endtask

    task automatic chk_alu(input string tag, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
        i_opsel = sel;
        i_op1   = a;
        i_op2   = b;
        #1;
        chk32({tag, "_res"}, o_result, exp_res);
        chk32({tag, "_zero"}, {31'd0, o_alu_zero}, {31'd0, exp_zero});
    endtask

    task automatic chk_br(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic exp_en);
        logic exp;
`ifdef BRANCH_EVAL_EN
        exp = exp_en;
`else
        exp = 1'b0 & exp_en;
`endif
        ctrl_if.i_opcode = opc;
        i_funct3 = f3;
        i_op1    = a;
        i_op2    = b;
        #1;
        chk32(tag, {31'd0, o_branch_taken}, {31'd0, exp});
    endtask

    initial begin
        ctrl_if.i_opcode = 7'd0;

        // Reset asserted mid-cycle: PC must load without any clock edge.
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        #1 chk32("rst_async", o_current_pc, 32'h0000_0100);
        i_next_pc = 32'h0000_0104;
        @(posedge i_clk);
        #1 chk32("rst_held", o_current_pc, 32'h0000_0100);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 chk32("pc_first", o_current_pc, 32'h0000_0104);

        for (int k = 0; k < 3; k++) begin
            i_next_pc = o_current_pc;
            @(posedge i_clk);
            #1 chk32($sformatf("pc_hold%0d", k), o_current_pc, 32'h0000_0104);
        end
        i_next_pc = 32'h0000_0203;
        @(posedge i_clk);
        #1 chk32("pc_misaligned", o_current_pc, 32'h0000_0203);

        chk_dec("dec_rtype",  7'b0110011, 13'b0010000000_010);
        chk_dec("dec_imm",    7'b0010011, 13'b1010000000_011);
        chk_dec("dec_load",   7'b0000011, 13'b1111000000_000);
        chk_dec("dec_store",  7'b0100011, 13'b1000100000_000);
        chk_dec("dec_branch", 7'b1100011, 13'b0000010000_001);
        chk_dec("dec_jal",    7'b1101111, 13'b0010001000_101);
        chk_dec("dec_jalr",   7'b1100111, 13'b1010000100_101);
        chk_dec("dec_lui",    7'b0110111, 13'b1010000010_100);
        chk_dec("dec_auipc",  7'b0010111, 13'b1010000001_100);
        chk_dec("dec_system", 7'b1110011, 13'b0000000000_000);
        chk_dec("dec_zero",   7'b0000000, 13'b0000000000_000);

        chk_alu("sub",      4'b1000, 32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0);
        chk_alu("sra",      4'b1101, 32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0);
        chk_alu("srl",      4'b0101, 32'h8000_0000, 32'd4,       32'h0800_0000, 1'b0);
        chk_alu("slt",      4'b0010, 32'hFFFF_FFFF, 32'd1,       32'd1,         1'b0);
        chk_alu("sltu",     4'b0011, 32'hFFFF_FFFF, 32'd1,       32'd0,         1'b1);
        chk_alu("slt_rev",  4'b0010, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b1);
        chk_alu("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1,       32'd0,         1'b1);
        chk_alu("sll_mask", 4'b0001, 32'd1,        32'h0000_0021, 32'd2,        1'b0);
        chk_alu("sra_mask", 4'b1101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0);
        chk_alu("xor",      4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        chk_alu("or",       4'b0110, 32'h00FF_00FF, 32'h0F0F_0F0F, 32'h0FFF_0FFF, 1'b0);
        chk_alu("and",      4'b0111, 32'h00FF_00FF, 32'h0F0F_0F0F, 32'h000F_000F, 1'b0);
        chk_alu("bad_sel",  4'b1111, 32'd5,        32'd3,        32'd0,         1'b1);

        chk_br("br_ge_eq",     7'b1100011, 3'b101, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b1);
        chk_br("br_ltu",       7'b1100011, 3'b110, 32'd1,         32'hFFFF_FFFF, 1'b1);
        chk_br("br_lt_signed", 7'b1100011, 3'b100, 32'hFFFF_FFFD, 32'd1,         1'b1);
        chk_br("br_eq_false",  7'b1100011, 3'b000, 32'd5,         32'd6,         1'b0);
        chk_br("br_ne",        7'b1100011, 3'b001, 32'd5,         32'd6,         1'b1);
        chk_br("br_geu_false", 7'b1100011, 3'b111, 32'd1,         32'hFFFF_FFFF, 1'b0);
        chk_br("br_f3_010",    7'b1100011, 3'b010, 32'd5,         32'd5,         1'b0);
        chk_br("br_not_br",    7'b0110011, 3'b000, 32'd5,         32'd5,         1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
